// File: rtl/namuru_evt_capture.sv
// Event capture for the namuru correlator: turns each toggle of the synchronized level into a pulse, sticky irq, counters and timestamp.
// Latency: one sys_clk cycle from an evt_sync change to every output; all outputs are registered.
// Backpressure: none; every enabled toggle is accepted, and overlap with a pending irq is counted as missed.
module namuru_evt_capture #(
  parameter int CNT_W = 16,
  parameter int TS_W  = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             evt_sync,
  input  logic             en,
  input  logic             ack,
  input  logic             cnt_clr,
  output logic             evt_pulse,
  output logic             irq,
  output logic [CNT_W-1:0] evt_count,
  output logic [CNT_W-1:0] missed_count,
  output logic [TS_W-1:0]  evt_stamp
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t           state_q;
  logic             prev_q;
  logic             evt_pulse_q;
  logic             irq_q;
  logic [TS_W-1:0]  ts_q;
  logic [TS_W-1:0]  ts_d;
  logic [TS_W-1:0]  stamp_q;
  logic [CNT_W-1:0] evt_count_q;
  logic [CNT_W-1:0] evt_count_d;
  logic [CNT_W-1:0] missed_q;
  logic [CNT_W-1:0] missed_d;
  logic             evt_hit;
  logic             missed_inc;

  // Any level change seen while enabled is one event; prev tracks regardless of en.
  assign evt_hit    = en & (evt_sync ^ prev_q);
  // An event landing on an already-pending irq is missed, unless the same-cycle ack lets it take over.
  assign missed_inc = evt_hit & irq_q & ~ack;

  // Next-state for the timestamp and the two counters; cnt_clr beats any increment.
  always_comb begin
    ts_d        = ts_q + TS_W'(1);
    evt_count_d = evt_count_q;
    missed_d    = missed_q;
    if (cnt_clr) begin
      evt_count_d = '0;
      missed_d    = '0;
    end else begin
      if (evt_hit) begin
        evt_count_d = evt_count_q + CNT_W'(1);
      end
      if (missed_inc && (missed_q != {CNT_W{1'b1}})) begin
        missed_d = missed_q + CNT_W'(1);
      end
    end
  end

  // Datapath registers: edge history, free-running timestamp, pulse and counters.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      prev_q      <= 1'b0;
      ts_q        <= '0;
      evt_pulse_q <= 1'b0;
      evt_count_q <= '0;
      missed_q    <= '0;
    end else begin
      prev_q      <= evt_sync;
      ts_q        <= ts_d;
      evt_pulse_q <= evt_hit;
      evt_count_q <= evt_count_d;
      missed_q    <= missed_d;
    end
  end

  // Pending machine: owns irq and the timestamp latch; a new event with ack re-latches the stamp.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
      stamp_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (evt_hit) begin
            state_q <= ST_PENDING;
            irq_q   <= 1'b1;
            stamp_q <= ts_q;
          end
        end
        ST_PENDING: begin
          if (evt_hit) begin
            if (ack) begin
              stamp_q <= ts_q;
            end
          end else if (ack) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign evt_pulse    = evt_pulse_q;
  assign irq          = irq_q;
  assign evt_count    = evt_count_q;
  assign missed_count = missed_q;
  assign evt_stamp    = stamp_q;

endmodule

// File: tb/tb_namuru_evt_capture.sv
// Bench for namuru_evt_capture: directed plan sequences plus random traffic against a queue-based scoreboard.
// Latency: expectations are pushed per stimulus cycle and popped one edge later by the monitor.
// Backpressure: none; the monitor consumes one expectation per clock while reset is released.
module tb_namuru_evt_capture;

  localparam int CNT_W = 4;
  localparam int TS_W  = 32;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             evt_sync = 1'b0;
  logic             en = 1'b0;
  logic             ack = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             evt_pulse;
  logic             irq;
  logic [CNT_W-1:0] evt_count;
  logic [CNT_W-1:0] missed_count;
  logic [TS_W-1:0]  evt_stamp;

  namuru_evt_capture #(.CNT_W(CNT_W), .TS_W(TS_W)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .evt_sync     (evt_sync),
    .en           (en),
    .ack          (ack),
    .cnt_clr      (cnt_clr),
    .evt_pulse    (evt_pulse),
    .irq          (irq),
    .evt_count    (evt_count),
    .missed_count (missed_count),
    .evt_stamp    (evt_stamp)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit          pulse;
    bit          irq;
    int unsigned cnt;
    int unsigned missed;
    longint      stamp;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: plain integers following the event rules directly.
  bit          m_prev;
  bit          m_pend;
  bit          m_pulse;
  int unsigned m_cnt;
  int unsigned m_missed;
  longint      m_ts;
  longint      m_stamp;

  task automatic chk(input string name, input longint act, input longint expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  task automatic model_reset();
    m_prev = 0; m_pend = 0; m_pulse = 0;
    m_cnt = 0; m_missed = 0; m_ts = 0; m_stamp = 0;
  endtask

  // Apply one cycle of inputs, predict the post-edge outputs, then wait for the next falling edge.
  task automatic step(input bit s, input bit e, input bit a, input bit c);
    exp_t x;
    bit ev;
    evt_sync = s; en = e; ack = a; cnt_clr = c;
    ev = e && (s != m_prev);
    m_prev = s;
    m_pulse = ev;
    if (c) begin
      m_cnt = 0;
      m_missed = 0;
    end else begin
      if (ev) m_cnt = (m_cnt + 1) % (CMAX + 1);
      if (ev && m_pend && !a && m_missed < CMAX) m_missed = m_missed + 1;
    end
    if (ev) begin
      if (!m_pend || a) m_stamp = m_ts;
      m_pend = 1;
    end else if (a) begin
      m_pend = 0;
    end
    m_ts = (m_ts + 1) % (64'd1 << TS_W);
    x.pulse = m_pulse; x.irq = m_pend; x.cnt = m_cnt;
    x.missed = m_missed; x.stamp = m_stamp;
    exp_q.push_back(x);
    @(negedge sys_clk);
  endtask

  // Monitor: one expectation consumed per clock edge, sampled just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge sys_clk);
      #1;
      if (!sys_rst && exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("sb_pulse",  longint'(evt_pulse),    longint'(x.pulse));
        chk("sb_irq",    longint'(irq),          longint'(x.irq));
        chk("sb_count",  longint'(evt_count),    longint'(x.cnt));
        chk("sb_missed", longint'(missed_count), longint'(x.missed));
        chk("sb_stamp",  longint'(evt_stamp),    x.stamp);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit s;
    longint t;
    model_reset();
    #1;
    chk("rst_pulse",  longint'(evt_pulse),    0);
    chk("rst_irq",    longint'(irq),          0);
    chk("rst_count",  longint'(evt_count),    0);
    chk("rst_missed", longint'(missed_count), 0);
    chk("rst_stamp",  longint'(evt_stamp),    0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    s = 0;

    // First event at cycle 10.
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    s = 1; step(s, 1, 0, 0);
    chk("first_pulse", longint'(evt_pulse), 1);
    chk("first_stamp", longint'(evt_stamp), 10);
    step(s, 1, 0, 0);
    chk("first_pulse_drop", longint'(evt_pulse), 0);

    // Three more events while pending, then ack.
    for (int i = 0; i < 3; i++) begin s = ~s; step(s, 1, 0, 0); end
    chk("pend_count",  longint'(evt_count),    4);
    chk("pend_missed", longint'(missed_count), 3);
    chk("pend_stamp",  longint'(evt_stamp),    10);
    step(s, 1, 1, 0);
    chk("ack_irq", longint'(irq), 0);

    // Event plus ack while pending.
    s = ~s; step(s, 1, 0, 0);
    step(s, 1, 0, 0);
    t = m_ts;
    s = ~s; step(s, 1, 1, 0);
    chk("evack_irq",    longint'(irq),          1);
    chk("evack_stamp",  longint'(evt_stamp),    t);
    chk("evack_missed", longint'(missed_count), 3);

    // Disabled capture ignores toggles; re-enable with steady input.
    for (int i = 0; i < 5; i++) begin s = ~s; step(s, 0, 0, 0); end
    step(s, 1, 0, 0);
    chk("en_pulse", longint'(evt_pulse), 0);
    chk("en_count", longint'(evt_count), 6);

    // Wrap and saturate, then clear coincident with an event.
    step(s, 1, 1, 1);
    for (int i = 0; i < 17; i++) begin s = ~s; step(s, 1, 0, 0); end
    chk("wrap_count",  longint'(evt_count),    1);
    chk("sat_missed",  longint'(missed_count), CMAX);
    s = ~s; step(s, 1, 0, 1);
    chk("clr_count",  longint'(evt_count),    0);
    chk("clr_missed", longint'(missed_count), 0);
    chk("clr_pulse",  longint'(evt_pulse),    1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 2) == 0) ? s : ~s;
      step(s, $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 24) == 0);
    end

    // Mid-burst reset with pending irq and nonzero counters.
    for (int i = 0; i < 3; i++) begin s = ~s; step(s, 1, 0, 0); end
    sys_rst = 1'b1;
    #1;
    chk("mrst_pulse",  longint'(evt_pulse),    0);
    chk("mrst_irq",    longint'(irq),          0);
    chk("mrst_count",  longint'(evt_count),    0);
    chk("mrst_missed", longint'(missed_count), 0);
    chk("mrst_stamp",  longint'(evt_stamp),    0);
    model_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    s = 1; step(s, 1, 0, 0);
    chk("rel_count", longint'(evt_count), 1);
    chk("rel_irq",   longint'(irq),       1);
    for (int i = 0; i < 4; i++) step(s, 1, 0, 0);

    chk("sb_drained", longint'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/namuru_evt_capture.md
# namuru_evt_capture

System-clock-domain event capture stage for the namuru GPS correlator. It consumes the synchronized toggle level produced by the correlator-to-system clock-domain synchronizer. Each level change marks one correlator event (accumulation interrupt or TIC). The block detects each event and turns it into a one-cycle pulse, a sticky interrupt with CPU acknowledge, an event counter, a missed-event counter and a timestamp latch for the CSR bank.

## Interface

Parameters:
- CNT_W, 16: width of evt_count and missed_count.
- TS_W, 32: width of the free-running timestamp counter and evt_stamp.

Ports:
- sys_clk  input  1  system clock; the only clock of the block.
- sys_rst  input  1  asynchronous, active-high reset.
- evt_sync  input  1  synchronized toggle level from the synchronizer; every transition (0->1 or 1->0) is one event.
- en  input  1  event capture enable.
- ack  input  1  one-cycle CSR strobe that clears irq.
- cnt_clr  input  1  one-cycle CSR strobe that zeroes evt_count and missed_count.
- evt_pulse  output  1  registered one-cycle pulse per accepted event.
- irq  output  1  sticky pending flag.
- evt_count  output  CNT_W  accepted events, modulo 2^CNT_W.
- missed_count  output  CNT_W  events accepted while irq was already pending; saturating.
- evt_stamp  output  TS_W  timestamp of the event that raised irq.

## Operation

- Internal prev register holds the last sampled evt_sync.
- prev tracks evt_sync every cycle regardless of en, so enabling capture never produces a spurious event.
- Event condition at a clock edge: en=1 and evt_sync != prev.
- Free-running counter ts increments every cycle. It wraps modulo 2^TS_W and is never cleared except by reset.
- On an event edge:
  - evt_pulse=1 for exactly that cycle; otherwise evt_pulse=0.
  - evt_count increments, wrapping from all-ones to 0.
- Two-state pending machine, IDLE (irq=0) and PENDING (irq=1):
  - IDLE + event -> PENDING; evt_stamp latches the current ts value (the value before the edge).
  - PENDING + ack, no event -> IDLE.
  - PENDING + event, no ack -> stay PENDING; missed_count increments, saturating at all-ones; evt_stamp holds.
  - PENDING + event + ack in the same cycle -> stay PENDING; evt_stamp relatches ts; missed_count unchanged. The new event wins and is not counted as missed.
  - IDLE + ack -> no effect.
- cnt_clr:
  - Sets evt_count and missed_count to 0 on that edge and takes priority over a simultaneous increment. A coincident event still pulses, sets or keeps irq, and latches evt_stamp per the rules above.
  - Does not affect irq, ts or evt_stamp.
- en=0: no events are accepted. irq, the counters and evt_stamp hold; ack and cnt_clr still act.

## Timing

- Reset (async assert, sync-clean release): evt_pulse=0, irq=0, evt_count=0, missed_count=0, evt_stamp=0, ts=0, prev=0.
- Latency: all outputs are registered. If evt_sync changes before edge k, evt_pulse, irq, the counters and evt_stamp all update at edge k, one cycle of this block.
- Back-to-back events (evt_sync toggling on consecutive cycles) are each accepted, giving consecutive evt_pulse cycles.
- Reset asserted mid-operation clears everything immediately, including pending state. After release, the first edge re-samples evt_sync into prev. If evt_sync=1 at release, one event is reported on that first edge.
- evt_stamp is stable while irq=1, except on the simultaneous event+ack case.

## Test plan

- Reset release with evt_sync=0, en=1. Toggle evt_sync once at cycle 10 (ts=10) -> evt_pulse high one cycle, irq=1, evt_count=1, evt_stamp=10, missed_count=0.
- With irq=1, toggle evt_sync 3 more times without ack -> evt_count=4, missed_count=3, evt_stamp=10. Then ack -> irq=0.
- Event and ack in the same cycle while pending -> irq stays 1, evt_stamp=new ts, missed_count unchanged.
- en=0, toggle evt_sync 5 times, then en=1 with evt_sync steady -> no pulse, evt_count unchanged, irq unchanged.
- CNT_W=4: 17 events with no ack -> evt_count=1 (wrapped), missed_count=15 (saturated). Then cnt_clr coincident with an event -> both counters 0, evt_pulse=1.
- Assert sys_rst mid-burst with irq=1 and counters nonzero -> all outputs 0 immediately. Release with evt_sync=1 -> one event on the first edge (evt_count=1, irq=1).
